// File: rtl/feed_pkg.sv
// Shared types and constants for the systolic feed controller.
// Holds the pass state encoding and the flush-length rule for both tile modes.
package feed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DONE
    } state_t;

    // Cycles needed for the last operand to cross the skew arrays and settle in the PEs
    function automatic int flush_len(input int n, input int pe_lat, input logic tile);
        return tile ? (2 * (n / 2 - 1) + pe_lat) : (2 * (n - 1) + pe_lat);
    endfunction

endpackage

// File: rtl/feed_counter.sv
// Up-counter with synchronous load-zero, count enable and terminal-count compare.
module feed_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_term,
    output logic         o_at_term
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_term = (r_count == i_term);

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Sequences one matrix-multiply pass: clear PEs, feed K vector pairs, flush the skew pipe, then signal done.
module systolic_feed_ctrl
    import feed_pkg::*;
#(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 16,
    parameter int K_WIDTH    = 8,
    parameter int PE_LAT     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    tile_cfg,
    input  logic [K_WIDTH-1:0]      k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N*DATA_WIDTH-1:0] a_vec_in,
    input  logic [N*DATA_WIDTH-1:0] b_vec_in,
    output logic [N*DATA_WIDTH-1:0] a_vec_out,
    output logic [N*DATA_WIDTH-1:0] b_vec_out,
    output logic                    feed_en,
    output logic                    tile,
    output logic                    pe_clear,
    output logic                    busy,
    output logic                    done
);

    localparam int FW = $clog2(2 * N + PE_LAT);
    localparam logic [FW-1:0] FLUSH_TERM_FULL = FW'(flush_len(N, PE_LAT, 1'b0) - 1);
    localparam logic [FW-1:0] FLUSH_TERM_TILE = FW'(flush_len(N, PE_LAT, 1'b1) - 1);

    state_t             r_state;
    state_t             w_next;
    logic [K_WIDTH-1:0] r_k_len;
    logic               r_tile;
    logic               w_transfer;
    logic               w_k_last;
    logic               w_flush_last;
    logic [FW-1:0]      w_flush_term;
    logic [K_WIDTH-1:0] w_k_term;

    assign w_transfer   = (r_state == FEED) && in_valid;
    assign w_flush_term = r_tile ? FLUSH_TERM_TILE : FLUSH_TERM_FULL;
    assign w_k_term     = r_k_len - 1'b1;

    // Counters are held at zero outside their own state, so each starts fresh on entry
    feed_counter #(.W(K_WIDTH)) u_k_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state != FEED),
        .i_en      (w_transfer),
        .i_term    (w_k_term),
        .o_at_term (w_k_last)
    );

    feed_counter #(.W(FW)) u_flush_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (r_state != FLUSH),
        .i_en      (r_state == FLUSH),
        .i_term    (w_flush_term),
        .o_at_term (w_flush_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_k_len <= '0;
            r_tile  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_k_len <= k_len;
                r_tile  <= tile_cfg;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = (r_k_len != '0) ? FEED : DONE;
            FEED:    if (w_transfer && w_k_last) w_next = FLUSH;
            FLUSH:   if (w_flush_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Vectors pass straight through only on a handshake; otherwise the skew arrays see zeros
    always_comb begin
        in_ready  = (r_state == FEED);
        feed_en   = w_transfer || (r_state == FLUSH);
        a_vec_out = w_transfer ? a_vec_in : '0;
        b_vec_out = w_transfer ? b_vec_in : '0;
        pe_clear  = (r_state == CLEAR);
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        tile      = r_tile;
    end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Directed bench for systolic_feed_ctrl (N=8, PE_LAT=1) with cycle windows worked out by hand per pass.
module tb_systolic_feed_ctrl;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int KW = 8;
    localparam int PL = 1;
    localparam int VW = N * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          tile_cfg;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] a_vec_in;
    logic [VW-1:0] b_vec_in;
    logic [VW-1:0] a_vec_out;
    logic [VW-1:0] b_vec_out;
    logic          feed_en;
    logic          tile;
    logic          pe_clear;
    logic          busy;
    logic          done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    systolic_feed_ctrl #(
        .N          (N),
        .DATA_WIDTH (DW),
        .K_WIDTH    (KW),
        .PE_LAT     (PL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tile_cfg  (tile_cfg),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec_in  (a_vec_in),
        .b_vec_in  (b_vec_in),
        .a_vec_out (a_vec_out),
        .b_vec_out (b_vec_out),
        .feed_en   (feed_en),
        .tile      (tile),
        .pe_clear  (pe_clear),
        .busy      (busy),
        .done      (done)
    );

    task automatic checkOutput(input string tag, input int cyc, input logic [VW-1:0] observed,
                               input logic [VW-1:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cyc, input logic startV, input logic validV, input logic rstV);
        rst_n    = rstV;
        start    = startV;
        in_valid = validV;
        for (int i = 0; i < N; i++) begin
            a_vec_in[i*DW +: DW] = DW'(cyc * 8 + i + 1);
            b_vec_in[i*DW +: DW] = DW'(16'hA000 + cyc * 8 + i);
        end
    endtask

    task automatic checkAll(input int cyc, input logic eReady, input logic eFeed, input logic eClear,
                            input logic eBusy, input logic eDone, input logic eTile,
                            input logic [VW-1:0] eA, input logic [VW-1:0] eB);
        checkOutput("in_ready",  cyc, VW'(in_ready), VW'(eReady));
        checkOutput("feed_en",   cyc, VW'(feed_en),  VW'(eFeed));
        checkOutput("pe_clear",  cyc, VW'(pe_clear), VW'(eClear));
        checkOutput("busy",      cyc, VW'(busy),     VW'(eBusy));
        checkOutput("done",      cyc, VW'(done),     VW'(eDone));
        checkOutput("tile",      cyc, VW'(tile),     VW'(eTile));
        checkOutput("a_vec_out", cyc, a_vec_out, eA);
        checkOutput("b_vec_out", cyc, b_vec_out, eB);
    endtask

    // One pass starting with start=1 in cycle 0; all expectation windows are supplied by the caller
    task automatic runPass(input int kLen, input logic tileCfg, input int stallFirst, input int stallLast,
                           input int feedLast, input int flushFirst, input int flushLast, input int doneCyc,
                           input logic prevTile, input int rstCyc, input int endCyc,
                           input int extraStart1, input int extraStart2);
        k_len    = KW'(kLen);
        tile_cfg = tileCfg;
        for (int c = 0; c <= endCyc; c++) begin
            logic sv;
            logic vv;
            logic inRst;
            logic eReady;
            logic eXfer;
            logic eTile;
            sv    = (c == 0) || (c == extraStart1) || (c == extraStart2);
            vv    = !(c >= stallFirst && c <= stallLast);
            inRst = (rstCyc >= 0) && (c > rstCyc);
            applyStimulus(c, sv, vv, (c == rstCyc) ? 1'b0 : 1'b1);
            #1;
            eReady = !inRst && (c >= 2) && (c <= feedLast);
            eXfer  = eReady && vv;
            eTile  = inRst ? 1'b0 : ((c >= 1) ? tileCfg : prevTile);
            checkAll(c, eReady,
                     eXfer || (!inRst && c >= flushFirst && c <= flushLast),
                     !inRst && (c == 1),
                     !inRst && (c >= 1) && (c <= doneCyc),
                     !inRst && (c == doneCyc),
                     eTile,
                     eXfer ? a_vec_in : '0,
                     eXfer ? b_vec_in : '0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tile_cfg = 1'b1;
        k_len    = 8'd3;
        applyStimulus(0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        checkAll(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        applyStimulus(0, 1'b0, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        checkAll(-1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);

        $display("[TB] k_len=4 full array, start re-pulsed in FEED and DONE");
        runPass(4, 1'b0, -1, -1, 5, 6, 20, 21, 1'b0, -1, 22, 3, 21);

        $display("[TB] k_len=4 tiled");
        runPass(4, 1'b1, -1, -1, 5, 6, 12, 13, 1'b0, -1, 15, -1, -1);

        $display("[TB] k_len=4 with in_valid low in cycles 3-4");
        runPass(4, 1'b0, 3, 4, 7, 8, 22, 23, 1'b1, -1, 24, -1, -1);

        $display("[TB] k_len=0");
        runPass(0, 1'b1, -1, -1, 1, 3, 2, 2, 1'b0, -1, 4, -1, -1);

        $display("[TB] reset in FLUSH at cycle 10");
        runPass(4, 1'b1, -1, -1, 5, 6, 12, 13, 1'b1, 10, 16, -1, -1);

        $display("[TB] k_len=2 after reset");
        runPass(2, 1'b0, -1, -1, 3, 4, 18, 19, 1'b0, -1, 20, -1, -1);

        $display("[TB] k_len=255 tiled");
        runPass(255, 1'b1, -1, -1, 256, 257, 263, 264, 1'b0, -1, 265, -1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
